pkt_fifo_stats_avlstrm: RTL and testbench
=========================================

Name: pkt_fifo_stats_avlstrm

Overview:
- Single-clock Avalon-ST packet FIFO with built-in instrumentation.
- Generalised successor of the per-channel FIFO+stats wrappers: parametrised data width, depth and almost-full threshold.
- Selectable cut-through or store-and-forward mode, with a deadlock-release path.
- Provides flit/packet/framing-error counters and a clearable high-watermark. Sits between pipeline stages wherever a buffered, observable hop is needed.

Parameters:
- DATA_W, 512, data bus width in bits.
- EMPTY_W, 6, empty field width; must equal log2(DATA_W/8).
- DEPTH, 512, FIFO entries; power of two, >= 4.
- AF_THRESH, DEPTH-16, fill level at or above which in_almost_full asserts.
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  input beat data.
- in_empty  in  EMPTY_W  empty bytes on eop beat.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_valid  in  1  beat valid.
- in_ready  out  1  FIFO can accept a beat.
- in_almost_full  out  1  fill_level >= AF_THRESH.
- out_data  out  DATA_W  head beat data.
- out_empty  out  EMPTY_W  head beat empty.
- out_sop  out  1  head sop.
- out_eop  out  1  head eop.
- out_valid  out  1  head beat presentable.
- out_ready  in  1  downstream accepts.
- stats_clear  in  1  synchronous clear of all stats.
- fill_level  out  $clog2(DEPTH)+1  current occupancy.
- max_fill_level  out  $clog2(DEPTH)+1  high-watermark since reset/clear.
- stat_flits  out  32  accepted input beats.
- stat_pkts  out  32  accepted input eop beats.
- stat_sops  out  32  accepted input sop beats.
- stat_frm_err  out  32  input framing errors.
- stat_release  out  32  store-and-forward deadlock releases.

Behaviour:
- Reset (Rst_n low, asynchronous): pointers, fill_level, complete-packet count, in-packet flag, max_fill_level and all stat_* go to 0. in_ready = 0 during reset and 1 from the first cycle after deassertion. out_valid = 0. in_almost_full = 0.
- Write handshake: write = in_valid & in_ready. in_ready = (fill_level < DEPTH). There is no same-cycle bypass at full: a read in the same cycle does not enable a write when full.
- Read handshake: read = out_valid & out_ready. The head fields are show-ahead and held stable while out_valid & !out_ready.
- fill_level: next = fill_level + write - read. A simultaneous write and read leaves it unchanged. Pointers wrap modulo DEPTH.
- Latency: a beat written at cycle N is visible at the head no earlier than N+1. In cut-through mode out_valid = (fill_level > 0).
- Store-and-forward mode:
  - A complete-packet counter increments on a written eop and decrements on a read eop. Both in the same cycle leave it unchanged.
  - out_valid = fill_level > 0 AND (pkt_cnt > 0 OR release_active).
  - release_active sets when fill_level == DEPTH and pkt_cnt == 0. stat_release increments at that set.
  - release_active clears after a read of an eop beat.
- in_almost_full is registered from fill_level; it lags fill_level by 1 cycle.
- max_fill_level updates to fill_level when fill_level > max_fill_level, 1-cycle lag.
- Counters increment on write beats only. stat_sops counts write & in_sop, stat_pkts counts write & in_eop, stat_flits counts every write.
- Framing: an in-packet flag sets on an sop write and clears on an eop write; sop & eop together is a single-beat packet and leaves the flag clear. A framing error is:
  - a sop write while the flag is set, or
  - a non-sop write while the flag is clear.
- stat_frm_err counts +1 per offending beat. Offending beats are still stored unmodified.
- All counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- stats_clear: on the next edge all stat_* and max_fill_level become 0. The clear wins over any increment in the same cycle; that event is lost. FIFO contents and fill_level are unaffected.
- Reset mid-packet discards all contents and the in-packet flag; no partial packet is emitted afterwards.

Test Plan:
- Cut-through: 3-beat packet (sop, -, eop, empty=5) with out_ready=1 -> out_valid 1 cycle after the first write; beats in order, out_empty=5; stat_flits=3, stat_pkts=1, stat_sops=1.
- Fill to full: DEPTH=16, AF_THRESH=12, out_ready=0, 20 valid beats -> in_ready low after 16 writes; in_almost_full high the cycle after fill_level=12; max_fill_level=16; stat_flits=16.
- Store-and-forward: STORE_FWD=1, send 4 beats without eop -> out_valid stays 0. Then send eop -> out_valid 1 a cycle later, with 5 beats draining.
- Deadlock release: STORE_FWD=1, DEPTH=16, 20-beat packet -> at fill 16 stat_release=1 and out_valid rises. The entire packet flows through, and release clears after the eop read.
- Framing errors: sop, sop, eop, then a lone data beat -> stat_frm_err=2, stat_sops=2, all 4 beats delivered.
- Clear and reset: stats_clear in the same cycle as a write -> all stats 0 afterwards (write stored, not counted). Assert Rst_n low mid-packet -> fill_level=0, out_valid=0 immediately, no stale beats after release.

Source files
------------

// File: rtl/pkt_fifo_stats_avlstrm.sv
`default_nettype none
// ============================================================================
// Module  : pkt_fifo_stats_avlstrm
// Brief   : Avalon-ST packet FIFO (cut-through / store-and-forward) with
//           flit, packet, sop, framing-error, release and watermark stats.
// Revision: 1.0 - initial release
// ============================================================================
module pkt_fifo_stats_avlstrm #(
    parameter int DATA_W    = 512,
    parameter int EMPTY_W   = 6,
    parameter int DEPTH     = 512,
    parameter int AF_THRESH = DEPTH - 16,
    parameter int STORE_FWD = 0
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [EMPTY_W-1:0]     in_empty,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   in_almost_full,
    output logic [DATA_W-1:0]      out_data,
    output logic [EMPTY_W-1:0]     out_empty,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   stats_clear,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [$clog2(DEPTH):0] max_fill_level,
    output logic [31:0]            stat_flits,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_sops,
    output logic [31:0]            stat_frm_err,
    output logic [31:0]            stat_release
);

    localparam int unsigned    c_aw   = $clog2(DEPTH);
    localparam int unsigned    c_bw   = DATA_W + EMPTY_W + 2;
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]  c_af   = (c_aw + 1)'(AF_THRESH);
    localparam bit             c_sf   = (STORE_FWD != 0);

    logic [c_bw-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_pkt_cnt;
    logic            r_release;
    logic            r_in_pkt;

    logic [c_bw-1:0] w_head;
    logic            w_write;
    logic            w_read;
    logic            w_wr_eop;
    logic            w_rd_eop;
    logic            w_rel_set;
    logic            w_frm_err;

    // in_ready is forced low while reset is asserted, not just after the first edge
    assign in_ready  = Rst_n & (fill_level < c_full);
    assign w_write   = in_valid & in_ready;
    assign w_read    = out_valid & out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign {out_sop, out_eop, out_empty, out_data} = w_head;
    assign w_wr_eop  = w_write & in_eop;
    assign w_rd_eop  = w_read & out_eop;
    assign w_rel_set = c_sf & ~r_release & (fill_level == c_full) & (r_pkt_cnt == '0);
    assign w_frm_err = w_write & (in_sop ? r_in_pkt : ~r_in_pkt);

    generate
        if (STORE_FWD != 0) begin : g_store_fwd
            // A full FIFO holding no complete packet would never drain; release it
            assign out_valid = (fill_level != '0) & ((r_pkt_cnt != '0) | r_release);
        end else begin : g_cut_through
            assign out_valid = (fill_level != '0);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {in_sop, in_eop, in_empty, in_data};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fill_level <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_write, w_read})
                2'b10:   fill_level <= fill_level + (c_aw + 1)'(1);
                2'b01:   fill_level <= fill_level - (c_aw + 1)'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pkt_cnt      <= '0;
            r_release      <= 1'b0;
            r_in_pkt       <= 1'b0;
            in_almost_full <= 1'b0;
        end else begin
            case ({w_wr_eop, w_rd_eop})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + (c_aw + 1)'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - (c_aw + 1)'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            if (w_rd_eop) begin
                r_release <= 1'b0;
            end else if (w_rel_set) begin
                r_release <= 1'b1;
            end
            // sop+eop together is a complete single-beat packet, flag stays clear
            if (w_write) begin
                r_in_pkt <= in_sop ? ~in_eop : (r_in_pkt & ~in_eop);
            end
            in_almost_full <= (fill_level >= c_af);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            max_fill_level <= '0;
            stat_flits     <= '0;
            stat_pkts      <= '0;
            stat_sops      <= '0;
            stat_frm_err   <= '0;
            stat_release   <= '0;
        end else if (stats_clear) begin
            max_fill_level <= '0;
            stat_flits     <= '0;
            stat_pkts      <= '0;
            stat_sops      <= '0;
            stat_frm_err   <= '0;
            stat_release   <= '0;
        end else begin
            if (fill_level > max_fill_level) begin
                max_fill_level <= fill_level;
            end
            stat_flits   <= stat_flits   + 32'(w_write);
            stat_pkts    <= stat_pkts    + 32'(w_wr_eop);
            stat_sops    <= stat_sops    + 32'(w_write & in_sop);
            stat_frm_err <= stat_frm_err + 32'(w_frm_err);
            stat_release <= stat_release + 32'(w_rel_set);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo_stats_avlstrm.sv
`default_nettype none
// ============================================================================
// Module  : tb_pkt_fifo_stats_avlstrm
// Brief   : Drives a cut-through and a store-and-forward instance with shared
//           stimulus and compares both against a queue-based packet model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pkt_fifo_stats_avlstrm;

    localparam int DW    = 64;
    localparam int EW    = 3;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [EW-1:0] in_empty = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          stats_clear = 1'b0;

    logic [1:0]         o_in_ready, o_af, o_sop, o_eop, o_valid;
    logic [1:0][DW-1:0] o_data;
    logic [1:0][EW-1:0] o_empty;
    logic [1:0][4:0]    o_fill, o_max;
    logic [1:0][31:0]   o_flits, o_pkts, o_sops, o_err, o_rel;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    // Instance 0 is cut-through, instance 1 is store-and-forward
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pkt_fifo_stats_avlstrm #(
            .DATA_W(DW), .EMPTY_W(EW), .DEPTH(DEPTH), .AF_THRESH(AFT), .STORE_FWD(g)
        ) u_dut (
            .Clk(Clk), .Rst_n(Rst_n),
            .in_data(in_data), .in_empty(in_empty), .in_sop(in_sop), .in_eop(in_eop),
            .in_valid(in_valid), .in_ready(o_in_ready[g]), .in_almost_full(o_af[g]),
            .out_data(o_data[g]), .out_empty(o_empty[g]), .out_sop(o_sop[g]),
            .out_eop(o_eop[g]), .out_valid(o_valid[g]), .out_ready(out_ready),
            .stats_clear(stats_clear), .fill_level(o_fill[g]), .max_fill_level(o_max[g]),
            .stat_flits(o_flits[g]), .stat_pkts(o_pkts[g]), .stat_sops(o_sops[g]),
            .stat_frm_err(o_err[g]), .stat_release(o_rel[g])
        );
    end

    // ---------------- reference model ----------------
    beat_t     mq0[$];
    beat_t     mq1[$];
    bit        m_rel[2], m_af[2], m_in_pkt[2];
    int        m_max[2];
    bit [31:0] m_flits[2], m_pkts[2], m_sops[2], m_err[2], m_release[2];

    function automatic int q_size(int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic beat_t q_head(int m);
        return (m == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic int q_eops(int m);
        int n = 0;
        if (m == 0) foreach (mq0[i]) n += int'(mq0[i].eop);
        else        foreach (mq1[i]) n += int'(mq1[i].eop);
        return n;
    endfunction

    function automatic bit exp_ready(int m);
        return Rst_n && (q_size(m) < DEPTH);
    endfunction

    function automatic bit exp_valid(int m);
        return (q_size(m) > 0) && (m == 0 || q_eops(m) > 0 || m_rel[m]);
    endfunction

    function automatic beat_t dut_head(int m);
        return {o_data[m], o_empty[m], o_sop[m], o_eop[m]};
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int m = 0; m < 2; m++) begin
            m_rel[m] = 0; m_af[m] = 0; m_in_pkt[m] = 0; m_max[m] = 0;
            m_flits[m] = 0; m_pkts[m] = 0; m_sops[m] = 0; m_err[m] = 0; m_release[m] = 0;
        end
    endtask

    // Advance model by one clock using the currently driven inputs, then clock the DUTs
    task automatic step();
        beat_t b;
        b = {in_data, in_empty, in_sop, in_eop};
        for (int m = 0; m < 2; m++) begin
            int    sz, eo;
            bit    vld, wr, rd, rd_eop, err;
            beat_t h;
            sz = q_size(m);
            eo = q_eops(m);
            vld = exp_valid(m);
            wr = in_valid && exp_ready(m);
            rd = vld && out_ready;
            h = (sz > 0) ? q_head(m) : '0;
            rd_eop = rd && h.eop;
            err = in_sop ? m_in_pkt[m] : !m_in_pkt[m];
            if (Rst_n) begin
                if (rd_eop) m_rel[m] = 0;
                else if (m == 1 && !m_rel[m] && sz == DEPTH && eo == 0) begin
                    m_rel[m] = 1;
                    if (!stats_clear) m_release[m] = m_release[m] + 1;
                end
                m_af[m] = (sz >= AFT);
                if (stats_clear) begin
                    m_max[m] = 0; m_flits[m] = 0; m_pkts[m] = 0; m_sops[m] = 0; m_err[m] = 0;
                    m_release[m] = 0;
                end else begin
                    if (sz > m_max[m]) m_max[m] = sz;
                    if (wr) begin
                        m_flits[m] = m_flits[m] + 1;
                        if (in_sop) m_sops[m] = m_sops[m] + 1;
                        if (in_eop) m_pkts[m] = m_pkts[m] + 1;
                        if (err)    m_err[m] = m_err[m] + 1;
                    end
                end
                if (wr) m_in_pkt[m] = in_sop ? !in_eop : (m_in_pkt[m] && !in_eop);
                if (m == 0) begin
                    if (rd) void'(mq0.pop_front());
                    if (wr) mq0.push_back(b);
                end else begin
                    if (rd) void'(mq1.pop_front());
                    if (wr) mq1.push_back(b);
                end
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [EW-1:0] emp);
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_empty = emp;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic clear_stats();
        drive(0, 0, 0, 0);
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_in_ready[m] !== 1'b0) begin
                failures++; $display("FAIL rst_in_ready m=%0d got=%0b exp=0", m, o_in_ready[m]);
            end
            checks++;
            if (o_valid[m] !== 1'b0) begin
                failures++; $display("FAIL rst_out_valid m=%0d got=%0b exp=0", m, o_valid[m]);
            end
        end
        Rst_n = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_in_ready[m] !== 1'b1) begin
                failures++; $display("FAIL rst_rel_in_ready m=%0d got=%0b exp=1", m, o_in_ready[m]);
            end
            checks++;
            if ({o_fill[m], o_max[m], o_af[m]} !== '0) begin
                failures++;
                $display("FAIL rst_levels m=%0d fill=%0d max=%0d af=%0b exp=0", m, o_fill[m], o_max[m], o_af[m]);
            end
            checks++;
            if ({o_flits[m], o_pkts[m], o_sops[m], o_err[m], o_rel[m]} !== '0) begin
                failures++; $display("FAIL rst_stats m=%0d flits=%0d pkts=%0d sops=%0d err=%0d rel=%0d exp=0",
                                     m, o_flits[m], o_pkts[m], o_sops[m], o_err[m], o_rel[m]);
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_cut_through();
        beat_t sent[$];
        beat_t got[$];
        clear_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 3) drive(1, c == 0, c == 2, (c == 2) ? 3'd5 : 3'd0);
            else       drive(0, 0, 0, 0);
            if (c < 3) sent.push_back({in_data, in_empty, in_sop, in_eop});
            if (o_valid[0] && out_ready) got.push_back(dut_head(0));
            if (c < 2) begin
                checks++;
                if (o_valid[0] !== (c == 1)) begin
                    failures++; $display("FAIL ct_latency c=%0d got=%0b exp=%0b", c, o_valid[0], c == 1);
                end
            end
            step();
        end
        checks++;
        if (got.size() != 3) begin
            failures++; $display("FAIL ct_beat_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++; $display("FAIL ct_beat[%0d] got=%h exp=%h", i, got[i], sent[i]);
                end
            end
            checks++;
            if (got[2].empty !== 3'd5) begin
                failures++; $display("FAIL ct_empty got=%0d exp=5", got[2].empty);
            end
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_flits[m] !== 32'd3 || o_pkts[m] !== 32'd1 || o_sops[m] !== 32'd1) begin
                failures++; $display("FAIL ct_stats m=%0d flits=%0d pkts=%0d sops=%0d exp=3/1/1",
                                     m, o_flits[m], o_pkts[m], o_sops[m]);
            end
        end
    endtask

    task automatic test_fill_full();
        int fill12 = -1;
        int af_rise = -1;
        clear_stats();
        out_ready = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) drive(1, c == 0, 0, 0);
            else        drive(0, 0, 0, 0);
            checks++;
            if (o_in_ready[0] !== exp_ready(0)) begin
                failures++; $display("FAIL full_in_ready c=%0d got=%0b exp=%0b", c, o_in_ready[0], exp_ready(0));
            end
            checks++;
            if (o_af[0] !== m_af[0]) begin
                failures++; $display("FAIL full_af c=%0d got=%0b exp=%0b", c, o_af[0], m_af[0]);
            end
            if (fill12 < 0 && q_size(0) == AFT) fill12 = c;
            if (af_rise < 0 && o_af[0] === 1'b1) af_rise = c;
            step();
        end
        checks++;
        if (af_rise != fill12 + 1) begin
            failures++; $display("FAIL full_af_lag got=%0d exp=%0d", af_rise, fill12 + 1);
        end
        checks++;
        if (o_fill[0] !== 5'd16 || o_max[0] !== 5'd16 || o_flits[0] !== 32'd16 || o_in_ready[0] !== 1'b0) begin
            failures++; $display("FAIL full_levels fill=%0d max=%0d flits=%0d rdy=%0b exp=16/16/16/0",
                                 o_fill[0], o_max[0], o_flits[0], o_in_ready[0]);
        end
        checks++;
        if (o_rel[1] !== 32'd1) begin
            failures++; $display("FAIL full_sf_release got=%0d exp=1", o_rel[1]);
        end
        out_ready = 1'b1;
        drive(0, 0, 0, 0);
        repeat (18) step();
        drive(1, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (4) step();
    endtask

    task automatic test_store_forward();
        beat_t sent[$];
        beat_t got[$];
        clear_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c < 5) drive(1, c == 0, c == 4, 0);
            else       drive(0, 0, 0, 0);
            if (c < 5) sent.push_back({in_data, in_empty, in_sop, in_eop});
            if (o_valid[1] && out_ready) got.push_back(dut_head(1));
            if (c >= 1 && c <= 5) begin
                checks++;
                if (o_valid[1] !== (c == 5)) begin
                    failures++; $display("FAIL sf_hold c=%0d got=%0b exp=%0b", c, o_valid[1], c == 5);
                end
            end
            step();
        end
        checks++;
        if (got.size() != 5) begin
            failures++; $display("FAIL sf_beat_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++; $display("FAIL sf_beat[%0d] got=%h exp=%h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_release();
        beat_t sent[$];
        beat_t got[$];
        int    idx = 0;
        int    full_c = -1;
        clear_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bit acc;
            if (idx < 20) drive(1, idx == 0, idx == 19, 0);
            else          drive(0, 0, 0, 0);
            acc = in_valid && exp_ready(1);
            if (acc) sent.push_back({in_data, in_empty, in_sop, in_eop});
            if (o_valid[1] && out_ready) got.push_back(dut_head(1));
            if (full_c < 0) begin
                checks++;
                if (o_valid[1] !== 1'b0) begin
                    failures++; $display("FAIL rel_early_valid c=%0d got=%0b exp=0", c, o_valid[1]);
                end
            end else if (c == full_c + 1) begin
                checks++;
                if (o_rel[1] !== 32'd1 || o_valid[1] !== 1'b1) begin
                    failures++; $display("FAIL rel_set rel=%0d valid=%0b exp=1/1", o_rel[1], o_valid[1]);
                end
            end
            if (full_c < 0 && q_size(1) == DEPTH) full_c = c;
            step();
            if (acc) idx++;
        end
        checks++;
        if (got.size() != 20) begin
            failures++; $display("FAIL rel_beat_count got=%0d exp=20", got.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++; $display("FAIL rel_beat[%0d] got=%h exp=%h", i, got[i], sent[i]);
                end
            end
        end
        // A new incomplete packet must be held again once the release has ended
        drive(1, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_valid[1] !== 1'b0) begin
                failures++; $display("FAIL rel_cleared c=%0d got=%0b exp=0", c, o_valid[1]);
            end
            step();
        end
        drive(1, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (6) step();
    endtask

    task automatic test_framing();
        int n_out = 0;
        clear_stats();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(1, c < 2, c == 2, 0);
            else       drive(0, 0, 0, 0);
            if (o_valid[0]) n_out++;
            step();
        end
        checks++;
        if (n_out != 4) begin
            failures++; $display("FAIL frm_delivered got=%0d exp=4", n_out);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_err[m] !== 32'd2 || o_sops[m] !== 32'd2 || o_flits[m] !== 32'd4) begin
                failures++; $display("FAIL frm_stats m=%0d err=%0d sops=%0d flits=%0d exp=2/2/4",
                                     m, o_err[m], o_sops[m], o_flits[m]);
            end
        end
    endtask

    task automatic test_clear_reset();
        beat_t fresh;
        out_ready = 1'b0;
        drive(1, 1, 1, 0);
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        drive(0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({o_flits[m], o_pkts[m], o_sops[m], o_err[m], o_max[m]} !== '0) begin
                failures++; $display("FAIL clr_stats m=%0d flits=%0d pkts=%0d sops=%0d max=%0d exp=0",
                                     m, o_flits[m], o_pkts[m], o_sops[m], o_max[m]);
            end
            checks++;
            if (o_fill[m] !== 5'(q_size(m))) begin
                failures++; $display("FAIL clr_fill m=%0d got=%0d exp=%0d", m, o_fill[m], q_size(m));
            end
        end
        drive(1, 1, 0, 0);
        step();
        drive(1, 0, 0, 0);
        step();
        Rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_fill[m] !== 5'd0 || o_valid[m] !== 1'b0) begin
                failures++; $display("FAIL mid_rst m=%0d fill=%0d valid=%0b exp=0/0", m, o_fill[m], o_valid[m]);
            end
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (o_valid[m] !== 1'b0) begin
                    failures++; $display("FAIL stale_beat m=%0d c=%0d got=%0b exp=0", m, c, o_valid[m]);
                end
            end
            step();
        end
        drive(1, 1, 1, 3'd2);
        fresh = {in_data, in_empty, in_sop, in_eop};
        step();
        drive(0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_valid[m] !== 1'b1 || dut_head(m) !== fresh) begin
                failures++; $display("FAIL post_rst_beat m=%0d valid=%0b got=%h exp=%h",
                                     m, o_valid[m], dut_head(m), fresh);
            end
        end
        repeat (3) step();
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 600; c++) begin
            bit slow;
            slow = ((c / 100) % 2) == 1;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  EW'($urandom));
            out_ready   = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            stats_clear = ($urandom_range(0, 63) == 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (o_in_ready[m] !== exp_ready(m)) begin
                    failures++; $display("FAIL rnd_in_ready m=%0d c=%0d got=%0b exp=%0b", m, c, o_in_ready[m], exp_ready(m));
                end
                checks++;
                if (o_valid[m] !== exp_valid(m)) begin
                    failures++; $display("FAIL rnd_valid m=%0d c=%0d got=%0b exp=%0b", m, c, o_valid[m], exp_valid(m));
                end
                checks++;
                if (o_fill[m] !== 5'(q_size(m)) || o_max[m] !== 5'(m_max[m]) || o_af[m] !== m_af[m]) begin
                    failures++; $display("FAIL rnd_levels m=%0d c=%0d fill=%0d/%0d max=%0d/%0d af=%0b/%0b",
                                         m, c, o_fill[m], q_size(m), o_max[m], m_max[m], o_af[m], m_af[m]);
                end
                if (exp_valid(m)) begin
                    checks++;
                    if (dut_head(m) !== q_head(m)) begin
                        failures++; $display("FAIL rnd_head m=%0d c=%0d got=%h exp=%h", m, c, dut_head(m), q_head(m));
                    end
                end
            end
            step();
        end
        stats_clear = 1'b0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (o_flits[m] !== m_flits[m] || o_pkts[m] !== m_pkts[m] || o_sops[m] !== m_sops[m] ||
                o_err[m] !== m_err[m] || o_rel[m] !== m_release[m]) begin
                failures++; $display("FAIL rnd_stats m=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
                                     m, o_flits[m], o_pkts[m], o_sops[m], o_err[m], o_rel[m],
                                     m_flits[m], m_pkts[m], m_sops[m], m_err[m], m_release[m]);
            end
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cut_through();
        test_fill_full();
        test_store_forward();
        test_release();
        test_framing();
        test_clear_reset();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
